// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave front end. Receives 2-bit-command + payload
// frames on MOSI and hands them to the backend on rx_data/rx_valid. It also
// serves read transactions: an address frame, then a data frame, then a
// readback word that is shifted out on MISO.
// Optional feature macro: SPI_SLAVE_PARITY_EN. When defined, each frame has a
// trailing odd-parity bit, rx_err reports parity errors, and MISO appends an
// odd-parity bit after the readback word.
module spi_slave_frame #(
    parameter int PAYLOAD_W = 8,
    parameter int TX_W      = 8,
    parameter int CNT_W     = $clog2((((PAYLOAD_W + 2) > TX_W) ? (PAYLOAD_W + 2) : TX_W) + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    input  logic                   tx_valid,
    input  logic [TX_W-1:0]        tx_data,
`ifdef SPI_SLAVE_PARITY_EN
    output logic                   rx_err,
`endif
    output logic                   MISO,
    output logic [PAYLOAD_W+1:0]   rx_data,
    output logic                   rx_valid,
    output logic                   tx_ready,
    output logic                   rd_pending
);

    localparam int FRAME_W = PAYLOAD_W + 2;

`ifdef SPI_SLAVE_PARITY_EN
    // All frame bits are held; the parity bit arrives on the final edge.
    localparam int RX_BITS = FRAME_W + 1;
    localparam int SH_W    = FRAME_W;
`else
    // The last frame bit goes straight from MOSI into rx_data.
    localparam int RX_BITS = FRAME_W;
    localparam int SH_W    = FRAME_W - 1;
`endif

    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_BITS - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHK_CMD   = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ_ADD  = 3'd3;
    localparam logic [2:0] S_READ_DATA = 3'd4;
    localparam logic [2:0] S_TX_WAIT   = 3'd5;
    localparam logic [2:0] S_TX_SHIFT  = 3'd6;
    localparam logic [2:0] S_HOLD      = 3'd7;

    logic [2:0]      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] tx_cnt;
    logic [SH_W-1:0]  shreg;
    logic [TX_W-1:0]  tx_sh;
    logic             frame_ok;
`ifdef SPI_SLAVE_PARITY_EN
    logic             tx_par;
`endif

    // Frame integrity on the completing edge: odd parity over frame + parity bit.
    always_comb begin
        frame_ok = 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
        frame_ok = ^{shreg, MOSI};
`endif
    end

    // Main frame FSM: reception, readback handshake, MISO shifting and abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            tx_cnt     <= '0;
            shreg      <= '0;
            tx_sh      <= '0;
            MISO       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            rd_pending <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
            rx_err     <= 1'b0;
            tx_par     <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!SS_n) state <= S_CHK_CMD;
                end

                S_CHK_CMD: begin
                    bit_cnt <= '0;
                    if (SS_n)
                        state <= S_IDLE;
                    else if (!MOSI)
                        state <= S_WRITE;
                    else if (rd_pending)
                        state <= S_READ_DATA;
                    else
                        state <= S_READ_ADD;
                end

                S_WRITE, S_READ_ADD, S_READ_DATA: begin
                    if (bit_cnt == RX_LAST) begin
                        // Last bit completes the frame even if SS_n rises on this edge.
                        bit_cnt  <= '0;
                        rx_valid <= 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
                        rx_data  <= shreg;
                        rx_err   <= ~frame_ok;
`else
                        rx_data  <= {shreg, MOSI};
`endif
                        if (state == S_READ_ADD && frame_ok)
                            rd_pending <= 1'b1;
                        if (SS_n)
                            state <= S_IDLE;
                        else if (state == S_READ_DATA && frame_ok) begin
                            state    <= S_TX_WAIT;
                            tx_ready <= 1'b1;
                        end else
                            state <= S_HOLD;
                    end else if (SS_n) begin
                        // Partial frame discarded.
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
                        shreg   <= {shreg[SH_W-2:0], MOSI};
`else
                        shreg   <= {shreg[SH_W-2:0], MOSI};
`endif
                    end
                end

                S_TX_WAIT: begin
                    if (SS_n) begin
                        state    <= S_IDLE;
                        tx_ready <= 1'b0;
                    end else if (tx_valid) begin
                        tx_sh    <= tx_data;
                        tx_cnt   <= '0;
                        tx_ready <= 1'b0;
                        state    <= S_TX_SHIFT;
`ifdef SPI_SLAVE_PARITY_EN
                        tx_par   <= ~^tx_data;
`endif
                    end
                end

                S_TX_SHIFT: begin
                    if (SS_n) begin
                        // rd_pending kept so the master can retry the data read.
                        state  <= S_IDLE;
                        MISO   <= 1'b0;
                        tx_cnt <= '0;
                    end else begin
`ifdef SPI_SLAVE_PARITY_EN
                        if (tx_cnt == CNT_W'(TX_W)) begin
                            MISO       <= tx_par;
                            tx_cnt     <= '0;
                            rd_pending <= 1'b0;
                            state      <= S_HOLD;
                        end else begin
                            MISO   <= tx_sh[TX_W-1];
                            tx_sh  <= tx_sh << 1;
                            tx_cnt <= tx_cnt + 1'b1;
                        end
`else
                        MISO  <= tx_sh[TX_W-1];
                        tx_sh <= tx_sh << 1;
                        if (tx_cnt == TX_LAST) begin
                            tx_cnt     <= '0;
                            rd_pending <= 1'b0;
                            state      <= S_HOLD;
                        end else
                            tx_cnt <= tx_cnt + 1'b1;
`endif
                    end
                end

                S_HOLD: begin
                    MISO <= 1'b0;
                    if (SS_n) state <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    MISO     <= 1'b0;
                    tx_ready <= 1'b0;
                    bit_cnt  <= '0;
                    tx_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed testbench for spi_slave_frame (default build, no parity).
module tb_spi_slave_frame;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        MISO;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic        rd_pending;

    int n_tests = 0;
    int n_fail  = 0;
    int rv_cnt  = 0;
    int rv_dbl  = 0;
    int miso_hi = 0;
    logic rv_prev = 1'b0;

    spi_slave_frame #(.PAYLOAD_W(8), .TX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .tx_valid(tx_valid), .tx_data(tx_data), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .rd_pending(rd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs are changed and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_valid) begin
            rv_cnt++;
            if (rv_prev) rv_dbl++;
        end
        rv_prev = rx_valid;
        if (MISO) miso_hi++;
    endtask

    // SS_n low from IDLE, command bit, then the 10 frame bits MSB first.
    task automatic rx_frame(input logic cmd, input logic [9:0] f, input logic ss_last);
        SS_n = 1'b0; MOSI = 1'b0; tick();
        MOSI = cmd; tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            if (i == 0 && ss_last) SS_n = 1'b1;
            tick();
        end
    endtask

    initial begin
        int rv0;
        logic [7:0] seq;
        logic       stay_ok;

        // Reset state
        rst_n = 1'b0; tick(); tick();
        chk("rst_miso", MISO, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rd_pending", rd_pending, 0);
        rst_n = 1'b1; tick();

        // Write frame
        rv0 = rv_cnt; miso_hi = 0;
        rx_frame(1'b0, 10'b00_1010_0011, 1'b0);
        chk("wr_rx_valid", rx_valid, 1);
        chk("wr_rx_data", rx_data, 10'h0A3);
        MOSI = 1'b1; tick(); tick();
        chk("wr_rx_valid_drop", rx_valid, 0);
        chk("wr_pulses", rv_cnt - rv0, 1);
        chk("wr_rd_pending", rd_pending, 0);
        chk("wr_miso_quiet", miso_hi, 0);
        SS_n = 1'b1; tick();

        // Read-address frame
        rx_frame(1'b1, 10'b10_0001_0000, 1'b0);
        chk("ra_rx_data", rx_data, 10'h210);
        chk("ra_rd_pending", rd_pending, 1);
        SS_n = 1'b1; tick();

        // Read-data frame with delayed backend
        rx_frame(1'b1, 10'b11_0000_0000, 1'b0);
        chk("rd_rx_data", rx_data, 10'h300);
        chk("rd_tx_ready", tx_ready, 1);
        stay_ok = 1'b1; miso_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!tx_ready) stay_ok = 1'b0;
        end
        chk("wait_tx_ready_held", stay_ok, 1);
        chk("wait_miso_quiet", miso_hi, 0);
        tx_valid = 1'b1; tx_data = 8'hA5; tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        chk("cap_tx_ready", tx_ready, 0);
        chk("cap_rd_pending", rd_pending, 1);
        for (int i = 7; i >= 0; i--) begin
            tick();
            seq[i] = MISO;
        end
        chk("tx_miso_seq", seq, 8'hA5);
        chk("tx_rd_pending_clr", rd_pending, 0);
        tick();
        chk("tx_miso_idle", MISO, 0);
        SS_n = 1'b1; tick();

        // Abort after 5 frame bits
        rv0 = rv_cnt;
        SS_n = 1'b0; MOSI = 1'b0; tick();
        tick();
        for (int i = 0; i < 5; i++) begin MOSI = i[0]; tick(); end
        SS_n = 1'b1; tick(); tick();
        chk("abort_no_pulse", rv_cnt - rv0, 0);
        chk("abort_rx_data", rx_data, 10'h300);

        // Abort during TX_SHIFT keeps rd_pending; next read goes to READ_DATA
        rx_frame(1'b1, 10'h255, 1'b0);
        SS_n = 1'b1; tick();
        rx_frame(1'b1, 10'h300, 1'b0);
        chk("ab2_read_data_path", tx_ready, 1);
        tx_valid = 1'b1; tx_data = 8'h3C; tick();
        tx_valid = 1'b0;
        tick(); tick(); tick();
        SS_n = 1'b1; tick();
        chk("ab2_miso", MISO, 0);
        chk("ab2_rd_pending", rd_pending, 1);
        chk("ab2_tx_ready", tx_ready, 0);
        rx_frame(1'b1, 10'h3FF, 1'b0);
        chk("retry_read_data_path", tx_ready, 1);
        chk("retry_rx_data", rx_data, 10'h3FF);
        SS_n = 1'b1; tick();

        // Reset during TX_SHIFT
        rx_frame(1'b1, 10'h301, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hFF; tick();
        tx_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_miso", MISO, 1);
        rst_n = 1'b0; tick();
        chk("mid_rst_miso", MISO, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rd_pending", rd_pending, 0);
        chk("mid_rst_tx_ready", tx_ready, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        rst_n = 1'b1; SS_n = 1'b1; tick();

        // Back-to-back writes separated by one SS_n-high cycle
        rv0 = rv_cnt;
        rx_frame(1'b0, 10'h155, 1'b0);
        SS_n = 1'b1; tick();
        rx_frame(1'b0, 10'h0CC, 1'b0);
        SS_n = 1'b1; tick();
        chk("b2b_pulses", rv_cnt - rv0, 2);
        chk("b2b_rx_data", rx_data, 10'h0CC);

        // SS_n rises on the last frame bit: frame still completes
        rv0 = rv_cnt;
        rx_frame(1'b0, 10'h05A, 1'b1);
        chk("sslast_rx_valid", rx_valid, 1);
        chk("sslast_rx_data", rx_data, 10'h05A);
        tick();
        rx_frame(1'b0, 10'h0F0, 1'b0);
        chk("sslast_next_frame", rx_data, 10'h0F0);
        chk("sslast_pulses", rv_cnt - rv0, 2);
        SS_n = 1'b1; tick();

        chk("rx_valid_never_double", rv_dbl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
